// File: rtl/instr_encoder_loader.sv
// instr_encoder_loader
//   Packs decoded instruction fields into 16-bit instruction words and writes
//   them to consecutive imem addresses during a load session.
//
//   Handshake: a request transfers on a rising edge where in_valid && in_ready.
//   in_ready is combinational from state, count, start and finish; it never
//   depends on in_valid. Illegal requests still transfer but produce no write.
//
//   Ports:
//     clk, reset          clock, synchronous active-high reset
//     start, finish       session begin / end pulses
//     in_valid, in_ready  request handshake
//     opcode, rd, rs1, rs2, immediate, nzimm, offset   decoded fields
//     imem_we, imem_addr, imem_wdata                   imem write port
//     count               words written this session
//     busy, done          in LOAD / one-cycle end-of-session pulse
//     err, err_code       sticky first error (1 opcode, 2 zero nzimm, 3 overflow)
//     dbg_state           current FSM state (0 IDLE, 1 LOAD, 2 DONE)
module instr_encoder_loader #(
   parameter int ADDR_W    = 8,
   parameter int DEPTH     = 256,
   parameter int BASE_ADDR = 0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              finish,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [3:0]        opcode,
   input  logic [2:0]        rd,
   input  logic [2:0]        rs1,
   input  logic [2:0]        rs2,
   input  logic [6:0]        immediate,
   input  logic [5:0]        nzimm,
   input  logic [8:0]        offset,
   output logic              imem_we,
   output logic [ADDR_W-1:0] imem_addr,
   output logic [15:0]       imem_wdata,
   output logic [ADDR_W:0]   count,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic [1:0]        err_code,
   output logic [1:0]        dbg_state
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_LOAD = 2'd1,
      S_DONE = 2'd2
   } state_t;

   localparam logic [ADDR_W:0]   DEPTH_C = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W-1:0] BASE_C  = ADDR_W'(BASE_ADDR);

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   ptr_q;
   logic                we_q;
   logic [ADDR_W-1:0]   addr_q;
   logic [15:0]         wdata_q;
   logic [ADDR_W:0]     count_q;
   logic                err_q;
   logic [1:0]          code_q;

   logic [15:0]         enc_word;
   logic [1:0]          enc_code;
   logic                session_init;
   logic                take;
   logic                overflow;

   // Field packing; enc_code is nonzero when the request must not be written.
   always_comb begin
      enc_word = 16'h0000;
      enc_code = 2'd0;
      case (opcode)
         4'd2, 4'd4, 4'd6, 4'd7: enc_word = {opcode, rd, rs1, rs2, 3'b000};
         4'd0, 4'd1, 4'd5:       enc_word = {opcode, rd, immediate, 2'b00};
         4'd3, 4'd8, 4'd9: begin
            enc_word = {opcode, rd, nzimm, 3'b000};
            if (nzimm == 6'd0) enc_code = 2'd2;
         end
         4'd10, 4'd11:           enc_word = {opcode, rs1, offset};
         default:                enc_code = 2'd1;
      endcase
   end

   // Next state and per-cycle control. start outranks finish outranks transfer.
   always_comb begin
      state_d      = state_q;
      in_ready     = 1'b0;
      session_init = 1'b0;
      take         = 1'b0;
      overflow     = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d      = S_LOAD;
               session_init = 1'b1;
            end
         end
         S_LOAD: begin
            if (start) begin
               session_init = 1'b1;
            end else if (finish) begin
               state_d = S_DONE;
            end else begin
               in_ready = (count_q < DEPTH_C);
               if (in_valid) begin
                  if (count_q < DEPTH_C) take     = 1'b1;
                  else                   overflow = 1'b1;
               end
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         ptr_q   <= BASE_C;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= 16'h0000;
         count_q <= '0;
         err_q   <= 1'b0;
         code_q  <= 2'd0;
      end else begin
         state_q <= state_d;
         we_q    <= 1'b0;
         if (session_init) begin
            count_q <= '0;
            ptr_q   <= BASE_C;
            err_q   <= 1'b0;
            code_q  <= 2'd0;
         end
         if (take) begin
            if (enc_code == 2'd0) begin
               we_q    <= 1'b1;
               addr_q  <= ptr_q;
               wdata_q <= enc_word;
               count_q <= count_q + 1'b1;
               ptr_q   <= ptr_q + 1'b1;   // wraps past all-ones
            end else if (!err_q) begin
               err_q  <= 1'b1;
               code_q <= enc_code;
            end
         end
         if (overflow && !err_q) begin
            err_q  <= 1'b1;
            code_q <= 2'd3;
         end
      end
   end

   // A write pending when reset rises is suppressed immediately, not a cycle late.
   assign imem_we    = we_q & ~reset;
   assign imem_addr  = addr_q;
   assign imem_wdata = wdata_q;
   assign count      = count_q;
   assign err        = err_q;
   assign err_code   = code_q;
   assign busy       = (state_q == S_LOAD);
   assign done       = (state_q == S_DONE);
   assign dbg_state  = state_q;

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Bench for instr_encoder_loader: two instances (default geometry, and
// DEPTH=4 / BASE_ADDR=254) share one stimulus stream; a behavioural model
// predicts both every cycle, alongside table vectors and directed sequences.
module tb_instr_encoder_loader;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       reset, start, finish, in_valid;
   logic [3:0] opcode;
   logic [2:0] rd, rs1, rs2;
   logic [6:0] immediate;
   logic [5:0] nzimm;
   logic [8:0] offset;

   logic       in_ready_o [2];
   logic       we_o       [2];
   logic [7:0] addr_o     [2];
   logic [15:0] wdata_o   [2];
   logic [8:0] count_o    [2];
   logic       busy_o     [2];
   logic       done_o     [2];
   logic       err_o      [2];
   logic [1:0] code_o     [2];
   logic [1:0] state_o    [2];

   instr_encoder_loader #(.ADDR_W(8), .DEPTH(256), .BASE_ADDR(0)) dut_a (
      .clk(clk), .reset(reset), .start(start), .finish(finish),
      .in_valid(in_valid), .in_ready(in_ready_o[0]),
      .opcode(opcode), .rd(rd), .rs1(rs1), .rs2(rs2),
      .immediate(immediate), .nzimm(nzimm), .offset(offset),
      .imem_we(we_o[0]), .imem_addr(addr_o[0]), .imem_wdata(wdata_o[0]),
      .count(count_o[0]), .busy(busy_o[0]), .done(done_o[0]),
      .err(err_o[0]), .err_code(code_o[0]), .dbg_state(state_o[0]));

   instr_encoder_loader #(.ADDR_W(8), .DEPTH(4), .BASE_ADDR(254)) dut_b (
      .clk(clk), .reset(reset), .start(start), .finish(finish),
      .in_valid(in_valid), .in_ready(in_ready_o[1]),
      .opcode(opcode), .rd(rd), .rs1(rs1), .rs2(rs2),
      .immediate(immediate), .nzimm(nzimm), .offset(offset),
      .imem_we(we_o[1]), .imem_addr(addr_o[1]), .imem_wdata(wdata_o[1]),
      .count(count_o[1]), .busy(busy_o[1]), .done(done_o[1]),
      .err(err_o[1]), .err_code(code_o[1]), .dbg_state(state_o[1]));

   int tests = 0;
   int fails = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   int m_depth [2] = '{256, 4};
   int m_base  [2] = '{0, 254};
   bit m_load  [2];
   bit m_done  [2];
   int m_cnt   [2];
   int m_ptr   [2];
   bit m_err   [2];
   int m_code  [2];
   bit m_we    [2];
   int m_addr  [2];
   int m_wdata [2];

   function automatic void enc(input int op, input int f_rd, input int f_rs1, input int f_rs2,
                               input int imm, input int nz, input int off,
                               output int word, output int code);
      word = 0;
      code = 0;
      if (op == 2 || op == 4 || op == 6 || op == 7)
         word = op * 4096 + f_rd * 512 + f_rs1 * 64 + f_rs2 * 8;
      else if (op == 0 || op == 1 || op == 5)
         word = op * 4096 + f_rd * 512 + imm * 4;
      else if (op == 3 || op == 8 || op == 9) begin
         word = op * 4096 + f_rd * 512 + nz * 8;
         if (nz == 0) code = 2;
      end else if (op == 10 || op == 11)
         word = op * 4096 + f_rs1 * 512 + off;
      else
         code = 1;
   endfunction

   task automatic model_step();
      for (int k = 0; k < 2; k++) begin
         bit n_load = m_load[k], n_done = m_done[k], n_err = m_err[k], n_we = 1'b0;
         int n_cnt = m_cnt[k], n_ptr = m_ptr[k], n_code = m_code[k];
         int n_addr = m_addr[k], n_wdata = m_wdata[k];
         int w, c;
         if (reset) begin
            n_load = 0; n_done = 0; n_err = 0; n_cnt = 0; n_ptr = m_base[k];
            n_code = 0; n_addr = 0; n_wdata = 0;
         end else if (m_done[k]) begin
            n_done = 0;
         end else if (start) begin
            n_load = 1; n_cnt = 0; n_ptr = m_base[k]; n_err = 0; n_code = 0;
         end else if (m_load[k]) begin
            if (finish) begin
               n_load = 0; n_done = 1;
            end else if (in_valid) begin
               if (m_cnt[k] < m_depth[k]) begin
                  enc(opcode, rd, rs1, rs2, immediate, nzimm, offset, w, c);
                  if (c == 0) begin
                     n_we = 1; n_addr = m_ptr[k]; n_wdata = w;
                     n_cnt = m_cnt[k] + 1; n_ptr = (m_ptr[k] + 1) % 256;
                  end else if (!m_err[k]) begin
                     n_err = 1; n_code = c;
                  end
               end else if (!m_err[k]) begin
                  n_err = 1; n_code = 3;
               end
            end
         end
         m_load[k]  <= n_load;  m_done[k] <= n_done; m_err[k]  <= n_err;
         m_we[k]    <= n_we;    m_cnt[k]  <= n_cnt;  m_ptr[k]  <= n_ptr;
         m_code[k]  <= n_code;  m_addr[k] <= n_addr; m_wdata[k] <= n_wdata;
      end
   endtask

   always @(posedge clk) model_step();

   task automatic compare_model();
      for (int k = 0; k < 2; k++) begin
         bit exp_ready = m_load[k] && !start && !finish && (m_cnt[k] < m_depth[k]);
         check($sformatf("model%0d_in_ready", k), in_ready_o[k], exp_ready);
         check($sformatf("model%0d_imem_we", k), we_o[k], m_we[k] && !reset);
         check($sformatf("model%0d_imem_addr", k), addr_o[k], m_addr[k]);
         check($sformatf("model%0d_imem_wdata", k), wdata_o[k], m_wdata[k]);
         check($sformatf("model%0d_count", k), count_o[k], m_cnt[k]);
         check($sformatf("model%0d_busy", k), busy_o[k], m_load[k]);
         check($sformatf("model%0d_done", k), done_o[k], m_done[k]);
         check($sformatf("model%0d_err", k), err_o[k], m_err[k]);
         check($sformatf("model%0d_err_code", k), code_o[k], m_code[k]);
      end
   endtask

   // Inputs are driven at a falling edge; step samples 1 time unit later,
   // lets one rising edge pass and returns at the next falling edge.
   task automatic step();
      #1;
      compare_model();
      @(negedge clk);
   endtask

   task automatic set_fields(input logic [3:0] op, input logic [2:0] f_rd, input logic [2:0] f_rs1,
                             input logic [2:0] f_rs2, input logic [6:0] imm, input logic [5:0] nz,
                             input logic [8:0] off);
      opcode = op; rd = f_rd; rs1 = f_rs1; rs2 = f_rs2;
      immediate = imm; nzimm = nz; offset = off;
   endtask

   typedef struct {
      logic [3:0]  op;
      logic [2:0]  rd, rs1, rs2;
      logic [6:0]  imm;
      logic [5:0]  nz;
      logic [8:0]  off;
      logic [15:0] exp_wdata;
   } vec_t;

   vec_t vecs [7];
   logic [7:0] b_addrs [4];

   initial begin
      // unused fields carry junk to show they are ignored
      vecs[0] = '{4'd4,  3'd1, 3'd2, 3'd3, 7'h7F, 6'h15, 9'h1AA, 16'h4298};
      vecs[1] = '{4'd8,  3'd7, 3'd6, 3'd5, 7'h11, 6'h3F, 9'h0F0, 16'h8FF8};
      vecs[2] = '{4'd10, 3'd4, 3'd5, 3'd1, 7'h22, 6'h01, 9'h1FF, 16'hABFF};
      vecs[3] = '{4'd2,  3'd7, 3'd7, 3'd7, 7'h00, 6'h00, 9'h000, 16'h2FF8};
      vecs[4] = '{4'd11, 3'd6, 3'd0, 3'd6, 7'h55, 6'h2A, 9'h100, 16'hB100};
      vecs[5] = '{4'd9,  3'd0, 3'd3, 3'd2, 7'h40, 6'h01, 9'h055, 16'h9008};
      vecs[6] = '{4'd5,  3'd3, 3'd1, 3'd4, 7'h7F, 6'h00, 9'h1FF, 16'h57FC};
      b_addrs[0] = 8'd254; b_addrs[1] = 8'd255; b_addrs[2] = 8'd0; b_addrs[3] = 8'd1;

      reset = 1'b1; start = 1'b0; finish = 1'b0; in_valid = 1'b0;
      set_fields(4'd0, 3'd0, 3'd0, 3'd0, 7'd0, 6'd0, 9'd0);
      @(negedge clk);
      @(negedge clk);
      step();
      reset = 1'b0;
      #1;
      for (int k = 0; k < 2; k++) begin
         check("reset_in_ready", in_ready_o[k], 0);
         check("reset_imem_we", we_o[k], 0);
         check("reset_imem_addr", addr_o[k], 0);
         check("reset_imem_wdata", wdata_o[k], 0);
         check("reset_count", count_o[k], 0);
         check("reset_busy", busy_o[k], 0);
         check("reset_done", done_o[k], 0);
         check("reset_err", err_o[k], 0);
         check("reset_err_code", code_o[k], 0);
         check("reset_state", state_o[k], 0);
      end

      // first transfer
      start = 1'b1; step(); start = 1'b0;
      check("start_busy", busy_o[0], 1);
      set_fields(4'd0, 3'd2, 3'd0, 3'd0, 7'h55, 6'd0, 9'd0);
      in_valid = 1'b1; step(); in_valid = 1'b0;
      check("first_we", we_o[0], 1);
      check("first_addr", addr_o[0], 0);
      check("first_wdata", wdata_o[0], 16'h0554);
      check("first_count", count_o[0], 1);
      step();
      check("we_one_cycle", we_o[0], 0);

      // table vectors, back to back in a fresh session
      start = 1'b1; step(); start = 1'b0;
      in_valid = 1'b1;
      for (int i = 0; i < 7; i++) begin
         set_fields(vecs[i].op, vecs[i].rd, vecs[i].rs1, vecs[i].rs2, vecs[i].imm, vecs[i].nz, vecs[i].off);
         step();
         check($sformatf("vec%0d_we", i), we_o[0], 1);
         check($sformatf("vec%0d_addr", i), addr_o[0], i);
         check($sformatf("vec%0d_wdata", i), wdata_o[0], vecs[i].exp_wdata);
         check($sformatf("vec%0d_count", i), count_o[0], i + 1);
      end
      in_valid = 1'b0; step();

      // illegal opcode, then zero nzimm: first error wins; start clears
      start = 1'b1; step(); start = 1'b0;
      set_fields(4'd13, 3'd1, 3'd1, 3'd1, 7'd1, 6'd1, 9'd1);
      in_valid = 1'b1;
      #1 check("illegal_in_ready", in_ready_o[0], 1);
      step();
      check("illegal_we", we_o[0], 0);
      check("illegal_err", err_o[0], 1);
      check("illegal_code", code_o[0], 1);
      check("illegal_count", count_o[0], 0);
      set_fields(4'd3, 3'd1, 3'd1, 3'd1, 7'd1, 6'd0, 9'd1);
      step();
      check("first_err_wins", code_o[0], 1);
      in_valid = 1'b0; start = 1'b1; step(); start = 1'b0;
      check("start_clears_err", err_o[0], 0);
      check("start_clears_code", code_o[0], 0);
      in_valid = 1'b1; step(); in_valid = 1'b0;
      check("nzimm_zero_code", code_o[0], 2);
      check("nzimm_zero_we", we_o[0], 0);
      check("nzimm_zero_count", count_o[0], 0);

      // DEPTH=4 instance: address wrap and overflow
      start = 1'b1; step(); start = 1'b0;
      set_fields(4'd1, 3'd4, 3'd0, 3'd0, 7'h2A, 6'd0, 9'd0);
      in_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step();
         check($sformatf("wrap%0d_we", i), we_o[1], 1);
         check($sformatf("wrap%0d_addr", i), addr_o[1], b_addrs[i]);
         check($sformatf("wrap%0d_count", i), count_o[1], i + 1);
      end
      #1 check("full_in_ready", in_ready_o[1], 0);
      step();
      check("overflow_code", code_o[1], 3);
      check("overflow_count", count_o[1], 4);
      check("overflow_we", we_o[1], 0);
      in_valid = 1'b0;

      // finish together with in_valid
      start = 1'b1; step(); start = 1'b0;
      set_fields(4'd0, 3'd1, 3'd0, 3'd0, 7'h01, 6'd0, 9'd0);
      in_valid = 1'b1; step();
      finish = 1'b1;
      #1 check("finish_in_ready", in_ready_o[0], 0);
      step(); finish = 1'b0;
      check("finish_we", we_o[0], 0);
      check("finish_done", done_o[0], 1);
      check("finish_busy", busy_o[0], 0);
      check("finish_count", count_o[0], 1);
      step();
      check("after_done", done_o[0], 0);
      check("after_busy", busy_o[0], 0);
      check("after_in_ready", in_ready_o[0], 0);
      check("after_state", state_o[0], 0);
      in_valid = 1'b0;

      // start mid-session with a write pending
      start = 1'b1; step(); start = 1'b0;
      in_valid = 1'b1; step();
      start = 1'b1;
      #1 check("restart_pending_we", we_o[0], 1);
      check("restart_in_ready", in_ready_o[0], 0);
      step(); start = 1'b0; in_valid = 1'b0;
      check("restart_we", we_o[0], 0);
      check("restart_count", count_o[0], 0);
      check("restart_busy", busy_o[0], 1);

      // reset right after an accepted transfer
      in_valid = 1'b1; step(); in_valid = 1'b0;
      reset = 1'b1;
      #1 check("reset_drops_we", we_o[0], 0);
      step(); reset = 1'b0;
      check("reset2_addr", addr_o[0], 0);
      check("reset2_wdata", wdata_o[0], 0);
      check("reset2_count", count_o[0], 0);
      check("reset2_busy", busy_o[0], 0);
      check("reset2_state", state_o[0], 0);

      // randomized traffic against the model
      for (int n = 0; n < 4000; n++) begin
         reset    = ($urandom_range(0, 299) == 0);
         start    = ($urandom_range(0, 24) == 0);
         finish   = ($urandom_range(0, 39) == 0);
         in_valid = ($urandom_range(0, 9) < 7);
         opcode    = 4'($urandom_range(0, 15));
         rd        = 3'($urandom);
         rs1       = 3'($urandom);
         rs2       = 3'($urandom);
         immediate = 7'($urandom);
         nzimm     = ($urandom_range(0, 7) == 0) ? 6'd0 : 6'($urandom);
         offset    = 9'($urandom);
         step();
      end
      reset = 1'b0; start = 1'b0; finish = 1'b0; in_valid = 1'b0;
      step();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
